// File: rtl/regfile_onehot_wr.sv
// 8 x WIDTH register file with a one-hot write select and two registered read ports.
// Same-cycle write-to-read bypass; sticky Err flag for non-one-hot write selects.
module regfile_onehot_wr #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             WrEn,
  input  logic [7:0]       WrSel,
  input  logic [WIDTH-1:0] WrData,
  input  logic [2:0]       RdAddr1,
  input  logic [2:0]       RdAddr2,
  output logic [WIDTH-1:0] RdData1,
  output logic [WIDTH-1:0] RdData2,
  output logic             Err
);

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot8(input logic [7:0] sel);
    return (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
  endfunction

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;
  logic             err_q, err_d;
  logic             wr_legal_s;

  // Next-state: write decode, bypassed reads and sticky error.
  always_comb begin
    wr_legal_s = WrEn && is_onehot8(WrSel);
    for (int i = 0; i < 8; i++) begin
      if (wr_legal_s && WrSel[i]) begin
        regs_d[i] = WrData;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    if (wr_legal_s && WrSel[RdAddr1]) begin
      rd1_d = WrData;
    end else begin
      rd1_d = regs_q[RdAddr1];
    end
    if (wr_legal_s && WrSel[RdAddr2]) begin
      rd2_d = WrData;
    end else begin
      rd2_d = regs_q[RdAddr2];
    end
    err_d = err_q | (WrEn & ~wr_legal_s);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= RST_VAL;
      end
      rd1_q <= RST_VAL;
      rd2_q <= RST_VAL;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      err_q <= err_d;
    end
  end

  assign RdData1 = rd1_q;
  assign RdData2 = rd2_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed bench for regfile_onehot_wr: a behavioural model pushes expected
// outputs into a queue per driven cycle; they are popped and checked after the edge.
module tb_regfile_onehot_wr;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             e;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             WrEn;
  logic [7:0]       WrSel;
  logic [WIDTH-1:0] WrData;
  logic [2:0]       RdAddr1;
  logic [2:0]       RdAddr2;
  logic [WIDTH-1:0] RdData1;
  logic [WIDTH-1:0] RdData2;
  logic             Err;

  logic [WIDTH-1:0] m_regs [8];
  logic             m_err;
  exp_t             sb_q [$];
  int               checks;
  int               failures;

  regfile_onehot_wr #(.WIDTH(WIDTH), .RST_VAL(16'h0000)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .WrEn   (WrEn),
    .WrSel  (WrSel),
    .WrData (WrData),
    .RdAddr1(RdAddr1),
    .RdAddr2(RdAddr2),
    .RdData1(RdData1),
    .RdData2(RdData2),
    .Err    (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push model expectation, then pop and compare after the edge.
  task automatic step(input logic rstn, input logic en, input logic [7:0] sel,
                      input logic [WIDTH-1:0] data, input logic [2:0] a1,
                      input logic [2:0] a2, input string tag);
    exp_t e;
    exp_t got;
    logic legal;
    @(negedge clk);
    rst_n = rstn; WrEn = en; WrSel = sel; WrData = data; RdAddr1 = a1; RdAddr2 = a2;
    legal = en && ($countones(sel) == 1);
    if (!rstn) begin
      e.r1 = 16'h0000; e.r2 = 16'h0000; e.e = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_err = 1'b0;
    end else begin
      e.r1 = (legal && sel[a1]) ? data : m_regs[a1];
      e.r2 = (legal && sel[a2]) ? data : m_regs[a2];
      if (en && !legal) m_err = 1'b1;
      e.e = m_err;
      for (int i = 0; i < 8; i++) if (legal && sel[i]) m_regs[i] = data;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({tag, ".rd1"}, RdData1, got.r1);
    check({tag, ".rd2"}, RdData2, got.r2);
    check({tag, ".err"}, {15'd0, Err}, {15'd0, got.e});
  endtask

  initial begin
    checks = 0; failures = 0; m_err = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    rst_n = 1'b0; WrEn = 1'b0; WrSel = 8'h00; WrData = 16'h0000;
    RdAddr1 = 3'd0; RdAddr2 = 3'd0;

    // Reset, then every register reads back the reset value.
    step(1'b0, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, "reset");
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 8'h00, 16'h0000, 3'(i), 3'(7 - i), "rst_read");

    // Write reg i = 0x1111*i, then read it on both ports.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 8'(1 << i), 16'(16'h1111 * i), 3'((i + 1) % 8), 3'((i + 5) % 8), "wr_all");
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 8'h00, 16'h0000, 3'(i), 3'(i), "rd_all");

    // Bypass on both ports, then single-port bypass.
    step(1'b1, 1'b1, 8'h08, 16'hAAAA, 3'd0, 3'd1, "byp_setup");
    step(1'b1, 1'b1, 8'h08, 16'h5555, 3'd3, 3'd3, "bypass_both");
    step(1'b1, 1'b0, 8'h00, 16'h0000, 3'd3, 3'd3, "bypass_after");
    step(1'b1, 1'b1, 8'h01, 16'hC0DE, 3'd0, 3'd4, "bypass_one");

    // Illegal multi-bit select: no writes, no bypass, Err sets.
    step(1'b1, 1'b1, 8'h06, 16'hFFFF, 3'd1, 3'd2, "illegal_06");
    step(1'b1, 1'b0, 8'h00, 16'h0000, 3'd1, 3'd2, "illegal_hold");
    step(1'b0, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, "reset2");

    // Zero select also sets Err; Err holds through legal writes until reset.
    step(1'b1, 1'b1, 8'h00, 16'h1234, 3'd0, 3'd5, "illegal_00");
    step(1'b1, 1'b1, 8'h20, 16'h6789, 3'd5, 3'd0, "err_sticky");
    step(1'b1, 1'b0, 8'h00, 16'h0000, 3'd5, 3'd5, "err_sticky2");
    step(1'b0, 1'b0, 8'h00, 16'h0000, 3'd5, 3'd5, "reset3");

    // WrEn low ignores WrSel entirely.
    step(1'b1, 1'b1, 8'h10, 16'h4444, 3'd4, 3'd0, "pre_en0");
    step(1'b1, 1'b0, 8'hFF, 16'hBEEF, 3'd4, 3'd0, "en0_ff");
    step(1'b1, 1'b0, 8'h00, 16'h0000, 3'd4, 3'd7, "en0_after");

    // Reset dominates a concurrent legal write.
    step(1'b1, 1'b1, 8'h80, 16'h7777, 3'd7, 3'd7, "pre_rst");
    step(1'b0, 1'b1, 8'h80, 16'h1234, 3'd7, 3'd7, "rst_mid");
    step(1'b1, 1'b0, 8'h00, 16'h0000, 3'd7, 3'd4, "rst_mid_after");

    if (sb_q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
